// File: rtl/my_register_file.sv
// General-purpose register bank: WIDTH x DEPTH, two combinational read
// ports, one synchronous write port, synchronous clear, async reset.
module my_register_file #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int BYPASS   = 0,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] in,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             zero_hit;
  logic             wr_en;
  logic [AW-1:0]    ra [2];
  logic [WIDTH-1:0] rd [2];

  assign zero_hit = (ZERO_REG != 0) && (waddr == '0);
  assign wr_en    = load && !clear && !zero_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[waddr] <= in;
    end
  end

  assign ra[0] = raddr_a;
  assign ra[1] = raddr_b;

  // Zero register wins over bypass; reset forces 0 on both ports.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = regs[ra[p]];
      if ((ZERO_REG != 0) && (ra[p] == '0)) begin
        rd[p] = '0;
      end else if ((BYPASS != 0) && wr_en && (ra[p] == waddr)) begin
        rd[p] = in;
      end
      if (!reset_n) begin
        rd[p] = '0;
      end
    end
  end

  assign out_a = rd[0];
  assign out_b = rd[1];

endmodule

// File: doc/my_register_file.md
# my_register_file

Parametrised multi-word register bank. It generalises the single-bit load register to WIDTH-bit words × DEPTH entries, with two asynchronous read ports, one synchronous write port, a global synchronous clear, an asynchronous reset, optional write-to-read bypass, and an optional hard-wired zero register. It sits between the ALU datapath and the instruction decoder as the CPU's general-purpose register set.

## Interface
Parameters:
- WIDTH, 16, bits per register; ≥1
- DEPTH, 8, number of registers; power of two, ≥2
- BYPASS, 0, 1 = a read of the entry being written returns `in` in the same cycle
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes

Ports (AW = $clog2(DEPTH)):
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear of all entries
- load  input  1  write enable
- waddr  input  AW  write address
- in  input  WIDTH  write data
- raddr_a  input  AW  read address, port A
- raddr_b  input  AW  read address, port B
- out_a  output  WIDTH  read data, port A
- out_b  output  WIDTH  read data, port B

Clock port is `clk`; reset is asynchronous, active-low, named `reset_n`.

## Operation
- Storage: DEPTH registers, each WIDTH bits.
- Reset: reset_n low → all entries 0 immediately, with no clock required. Held low → writes and clears ignored. out_a and out_b read 0 during reset.
- Per rising edge, with reset_n high, in priority order:
  - clear=1 → all entries 0. Any simultaneous load is discarded.
  - clear=0, load=1 → entry[waddr] ← in. If ZERO_REG=1 and waddr=0, no entry changes.
  - otherwise → all entries hold.
- Reads are purely combinational:
  - out_x = entry[raddr_x].
  - ZERO_REG=1 and raddr_x=0 → out_x = 0.
- Bypass (BYPASS=1 only):
  - Condition: load=1, clear=0, reset_n=1, raddr_x=waddr, and the target is not the zero register.
  - Result: out_x = in combinationally.
  - BYPASS=0: out_x shows the old value until after the edge.
- Both ports may address the same entry; both return identical data.
- No arithmetic. Address widths are exact, so no out-of-range case exists.

## Timing
- Write latency:
  - 1 edge; the new value is visible on out_x after the edge that samples load=1.
  - BYPASS=1: also visible combinationally before the edge.
- Read latency: 0 cycles (combinational from raddr_x and stored state).
- Clear latency: 1 edge; all outputs read 0 after it.
- Reset assertion: asynchronous; outputs 0 within the same timestep, independent of clk.
- Reset deassertion: first effective write is the first rising edge with reset_n high.
- Reset mid-operation: a write coincident with the reset_n falling edge is lost; the entry ends at 0.
- Simultaneous write and read of different entries: the read returns the unaffected stored value.
- load changing while clk is high has no effect until the next rising edge.

## Test plan
- Reset: write 0x1234 to entry 3, then drop reset_n with clk held low → out_a (raddr_a=3) is 0x0000 immediately. After release, a write of 0xBEEF to entry 3 → out_a=0xBEEF after 1 edge.
- Load gating, checked at every address: load=0, in=0xFFFF, clk pulsed → entry unchanged. load=1 → entry=0xFFFF. Next edge with load=0, in=0x0000 → entry still 0xFFFF.
- Dual read: entry 2=0x00AA, entry 5=0x5500. raddr_a=2, raddr_b=5 → out_a=0x00AA, out_b=0x5500. Both ports on 5 → both read 0x5500.
- Clear priority: all entries non-zero, clear=1 and load=1 with waddr=4, in=0x7777 → after the edge every entry reads 0, including entry 4.
- Bypass: BYPASS=1, entry 6=0x0001. load=1, waddr=6, in=0x0F0F, raddr_a=6 → out_a=0x0F0F before the edge. Same stimulus with BYPASS=0 → out_a=0x0001 before the edge and 0x0F0F after it.
- Zero register: ZERO_REG=1, write 0xDEAD to entry 0 → out_a (raddr_a=0) stays 0, including under BYPASS=1. Entry 1 write of 0xDEAD reads back 0xDEAD.
